player_ctl_multi: RTL

PLAYER_CTL_MULTI -- requirements
Module: player_ctl_multi

---
 rtl/player_ctl_multi.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/player_ctl_multi.sv
// Multi-player platformer motion controller.
// Each player channel owns an x/y position, a vertical speed and a
// GROUND/RISE/FALL state machine, all advanced once per video frame
// on the rising edge of v_tick while the game is enabled.
module player_ctl_multi #(
    parameter int N_PLAYERS = 2,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 800,
    parameter int P_WIDTH   = 32,
    parameter int Y_FLOOR   = 500,
    parameter int STEP      = 4,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 12,
    parameter int X_START   = 100,
    parameter int X_SPACING = 400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   v_tick,
    input  logic                   enable,
    input  logic [N_PLAYERS-1:0]   move_left,
    input  logic [N_PLAYERS-1:0]   move_right,
    input  logic [N_PLAYERS-1:0]   jump,
    output logic [12*N_PLAYERS-1:0] xpos,
    output logic [12*N_PLAYERS-1:0] ypos,
    output logic [N_PLAYERS-1:0]   airborne,
    output logic                   frame_done
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    // 13-bit working constants leave one bit of headroom so that
    // x +/- STEP never wraps before it is compared against the bounds.
    localparam logic [12:0] X_LO13    = 13'(X_MIN);
    localparam logic [12:0] X_HI13    = 13'(X_MAX - P_WIDTH);
    localparam logic [12:0] STEP13    = 13'(STEP);
    localparam logic [12:0] Y_FLOOR13 = 13'(Y_FLOOR);
    localparam logic [11:0] Y_FLOOR12 = 12'(Y_FLOOR);
    localparam logic [8:0]  GRAV9     = 9'(GRAVITY);
    localparam logic [8:0]  VMAX9     = 9'(VMAX);
    localparam logic [7:0]  GRAV8     = 8'(GRAVITY);
    localparam logic [7:0]  JUMP8     = 8'(JUMP_V);

    // Horizontal move with saturation at both playfield edges.
    function automatic logic [11:0] step_x(input logic [11:0] x,
                                           input logic l,
                                           input logic r);
        logic [12:0] xw;
        xw = {1'b0, x};
        if (l && !r) begin
            if (xw < X_LO13 + STEP13) xw = X_LO13;
            else                      xw = xw - STEP13;
        end else if (r && !l) begin
            if (xw + STEP13 > X_HI13) xw = X_HI13;
            else                      xw = xw + STEP13;
        end
        return xw[11:0];
    endfunction

    // Upward move, saturating at the top of the screen.
    function automatic logic [11:0] rise_y(input logic [11:0] y,
                                           input logic [7:0] spd);
        logic [11:0] yw;
        if ({4'b0, spd} > y) yw = '0;
        else                 yw = y - {4'b0, spd};
        return yw;
    endfunction

    // Falling speed: accelerate by GRAVITY, capped at VMAX.
    function automatic logic [7:0] fall_speed(input logic [7:0] spd);
        logic [8:0] s;
        s = {1'b0, spd} + GRAV9;
        if (s > VMAX9) s = VMAX9;
        return s[7:0];
    endfunction

    logic v_tick_d;
    logic tick;
    logic frame_en;

    assign tick     = v_tick & ~v_tick_d;
    assign frame_en = tick & enable;

    // Frame edge detector and frame_done pulse, aligned with the position update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_tick_d   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            v_tick_d   <= v_tick;
            frame_done <= frame_en;
        end
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        localparam logic [11:0] X_RST = 12'(X_START + i * X_SPACING);

        state_t      state, state_nxt;
        logic [11:0] x, x_nxt;
        logic [11:0] y, y_nxt;
        logic [7:0]  speed, speed_nxt;
        logic [7:0]  spd_f;
        logic [12:0] land_sum;

        // Player state register; only advances on an enabled frame.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= GROUND;
                x     <= X_RST;
                y     <= Y_FLOOR12;
                speed <= '0;
            end else if (frame_en) begin
                state <= state_nxt;
                x     <= x_nxt;
                y     <= y_nxt;
                speed <= speed_nxt;
            end
        end

        // Next-frame position, speed and state for this player.
        always_comb begin
            state_nxt = state;
            y_nxt     = y;
            speed_nxt = speed;
            spd_f     = fall_speed(speed);
            land_sum  = {1'b0, y} + {5'b0, spd_f};
            x_nxt     = step_x(x, move_left[i], move_right[i]);
            case (state)
                GROUND: begin
                    if (jump[i]) begin
                        state_nxt = RISE;
                        speed_nxt = JUMP8;
                    end
                end
                RISE: begin
                    y_nxt = rise_y(y, speed);
                    if (speed <= GRAV8) begin
                        speed_nxt = '0;
                        state_nxt = FALL;
                    end else begin
                        speed_nxt = speed - GRAV8;
                    end
                end
                FALL: begin
                    if (land_sum >= Y_FLOOR13) begin
                        y_nxt     = Y_FLOOR12;
                        speed_nxt = '0;
                        state_nxt = GROUND;
                    end else begin
                        y_nxt     = land_sum[11:0];
                        speed_nxt = spd_f;
                    end
                end
                default: begin
                    state_nxt = GROUND;
                end
            endcase
        end

        assign xpos[12*i +: 12] = x;
        assign ypos[12*i +: 12] = y;
        assign airborne[i]      = (state != GROUND);
    end

endmodule
